// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with a programmable wait.
// Byte-lane stores, range/alignment error flag, memory array held locally.
module dmem_responder #(
  parameter int DepthWords = 1024,
  parameter int Latency    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DepthWords);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  req_t          hold_q;
  req_t          req_in;
  req_t          acc;
  logic          accept;
  logic          access;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   mem [DepthWords];

  assign req_in = '{
    write: req_write,
    addr:  req_addr,
    wdata: req_wdata,
    be:    req_be
  };

  assign req_ready = (state_q == IDLE) & rst;
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid & req_ready;

  // With zero latency the access uses the request as it is accepted
  assign acc_idx = acc.addr[AW+1:2];
  assign acc_err = (acc.addr[1:0] != 2'b00)
                 | ((acc.addr >> (AW + 2)) != 32'd0);

  // Next-state, counter and memory-access strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    acc     = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (Latency == 0) begin
            state_d = RESP;
            access  = 1'b1;
            acc     = req_in;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(Latency);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= req_in;
    end
  end

  // Response data and error, held until the next access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err <= acc_err;
      if (!acc.write && !acc_err) begin
        rsp_rdata <= mem[acc_idx];
      end else begin
        rsp_rdata <= '0;
      end
    end
  end

  // Lane-masked store into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (access && acc.write && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (acc.be[k]) begin
          mem[acc_idx][8*k +: 8] <= acc.wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of load/store vectors plus
// stall, reset-in-flight and zero-latency throughput sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DepthWords(1024), .Latency(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DepthWords(1024), .Latency(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Issue one request at a negedge, scramble inputs while busy,
  // then collect the response and release it.
  task automatic transact(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] rd, output logic er,
                          output int lat);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = a ^ 32'h4;
    req_wdata = ~d;
    req_be    = ~be;
    chk("rdy_busy", {31'd0, req_ready}, 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rdy_back", {31'd0, req_ready}, 32'd1);
    chk("vld_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;
    int          acc_n;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'hA, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[6]  = '{1'b1, 32'h0,   32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'h20,  32'h12345678, 4'hF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[12] = '{1'b1, 32'h80000000, 32'h77777777, 4'hF, 32'h0, 1'b1};
    vecs[13] = '{1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'hFFC, 32'h0,        4'h0, 32'h0BADCAFE, 1'b0};

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0;
    z_req_wdata = '0; z_req_be = '0; z_rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      transact(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, rd, er, lat);
      chk($sformatf("v%0d_lat", i), lat, 32'd3);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].er});
    end

    // Response stall: held stable, new requests ignored
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_lat", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_be = 4'hF;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDE22BE44);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_idle", {31'd0, req_ready}, 32'd1);
    chk("stall_vdrop", {31'd0, rsp_valid}, 32'd0);
    chk("stall_hold", rsp_rdata, 32'hDE22BE44);
    transact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("stall_noacc", rd, 32'hA5A5A5A5);

    // Reset while waiting: store is dropped, no response follows
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("wrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wrst_ready", {31'd0, req_ready}, 32'd0);
    chk("wrst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("wrst_norsp", seen, 32'd0);
    transact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("wrst_mem", rd, 32'h12345678);

    // Reset while a response is pending
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24;
    req_wdata = 32'h0F0F0F0F; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rrst_lat", lat, 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("rrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rrst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    transact(1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
    chk("rrst_mem24", rd, 32'h0F0F0F0F);
    transact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("rrst_mem20", rd, 32'h12345678);

    // Zero-latency build: one acceptance every two cycles
    z_req_valid = 1'b1; z_rsp_ready = 1'b1; z_req_write = 1'b1;
    z_req_addr = 32'h40; z_req_wdata = 32'h01020304; z_req_be = 4'hF;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      chk("z_ready", {31'd0, z_req_ready}, {31'd0, (i % 2) == 0});
      chk("z_valid", {31'd0, z_rsp_valid}, {31'd0, (i % 2) == 1});
      if (i == 11) chk("z_rdata", z_rsp_rdata, 32'h01020304);
      if (z_req_ready) acc_n++;
      if (i == 10) z_req_write = 1'b0;
      @(negedge clk);
    end
    chk("z_accepts", acc_n, 32'd10);
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
